branch_cond_unit: RTL and testbench

//  Consumer side of the ALU status-flag path: reads the registered {z,n,c,v} status

---
 rtl/branch_cond_if.sv | 23 ++
 rtl/branch_cond_unit.sv | 108 ++++++++++
 tb/tb_branch_cond_unit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/branch_cond_if.sv
// Decode-to-branch-unit request channel and branch-unit-to-PC-mux result channel.
interface branch_cond_if #(parameter int ADDR_W = 8);
   logic              br_valid;
   logic              br_ready;
   logic [3:0]        br_cond;
   logic [ADDR_W-1:0] br_target;
   logic [ADDR_W-1:0] pc_plus1;
   logic              res_valid;
   logic              res_ready;
   logic              take;
   logic [ADDR_W-1:0] next_pc;
   logic              illegal;

   modport master (
      output br_valid, br_cond, br_target, pc_plus1, res_ready,
      input  br_ready, res_valid, take, next_pc, illegal
   );

   modport slave (
      input  br_valid, br_cond, br_target, pc_plus1, res_ready,
      output br_ready, res_valid, take, next_pc, illegal
   );
endinterface

// File: rtl/branch_cond_unit.sv
// Conditional-jump evaluator: waits out flag writes, tests {z,n,c,v}, returns take/next_pc.
// Optional BRANCH_STATS_EN adds taken_cnt/eval_cnt counters.
module branch_cond_unit #(parameter int ADDR_W = 8) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  status,
   input  logic        flags_wr,
   branch_cond_if.slave bus
`ifdef BRANCH_STATS_EN
   , output logic [15:0] taken_cnt
   , output logic [15:0] eval_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, HOLD, EVAL, DONE} state_t;

   state_t            state, state_nxt;
   logic [3:0]        cond_q;
   logic [ADDR_W-1:0] target_q, pc1_q;
   logic              cond_take, cond_ill;
   logic              accept, release_res;

   assign accept      = bus.br_valid & bus.br_ready;
   assign release_res = (state == DONE) & bus.res_ready;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      bus.br_ready  = 1'b0;
      bus.res_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.br_ready = 1'b1;
            if (bus.br_valid) state_nxt = flags_wr ? HOLD : EVAL;
         end
         HOLD: if (!flags_wr) state_nxt = EVAL;
         // flags_wr is ignored here: status is already final for this evaluation
         EVAL: state_nxt = DONE;
         DONE: begin
            bus.res_valid = 1'b1;
            if (bus.res_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // condition table over the live status word {z,n,c,v}
   always_comb begin
      cond_take = 1'b0;
      cond_ill  = 1'b0;
      case (cond_q)
         4'd0:  cond_take = 1'b1;
         4'd1:  cond_take = status[3];
         4'd2:  cond_take = ~status[3];
         4'd3:  cond_take = ~status[3] & (status[2] == status[0]);
         4'd4:  cond_take = (status[2] == status[0]);
         4'd5:  cond_take = (status[2] != status[0]);
         4'd6:  cond_take = status[3] | (status[2] != status[0]);
         4'd7:  cond_take = status[1];
         4'd8:  cond_take = ~status[1];
         4'd9:  cond_take = status[0];
         4'd10: cond_take = ~status[0];
         default: cond_ill = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cond_q      <= '0;
         target_q    <= '0;
         pc1_q       <= '0;
         bus.take    <= 1'b0;
         bus.next_pc <= '0;
         bus.illegal <= 1'b0;
      end else begin
         if (accept) begin
            cond_q   <= bus.br_cond;
            target_q <= bus.br_target;
            pc1_q    <= bus.pc_plus1;
         end
         if (state == EVAL) begin
            bus.take    <= cond_take;
            bus.next_pc <= cond_take ? target_q : pc1_q;
            bus.illegal <= cond_ill;
         end
      end
   end

`ifdef BRANCH_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         taken_cnt <= '0;
         eval_cnt  <= '0;
      end else if (release_res) begin
         eval_cnt <= eval_cnt + 16'd1;
         if (bus.take) taken_cnt <= taken_cnt + 16'd1;
      end
   end
`else
   logic unused_release;
   assign unused_release = release_res;
`endif

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed + randomized checks of branch_cond_unit against a table-driven reference model.
module tb_branch_cond_unit;
   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] status;
   logic       flags_wr;
   int         checks = 0;
   int         errors = 0;
   int         exp_eval = 0;
   int         exp_taken = 0;

   branch_cond_if #(.ADDR_W(8)) bus ();

`ifdef BRANCH_STATS_EN
   logic [15:0] taken_cnt, eval_cnt;
   branch_cond_unit #(.ADDR_W(8)) dut (
      .clk(clk), .reset(reset), .status(status), .flags_wr(flags_wr), .bus(bus),
      .taken_cnt(taken_cnt), .eval_cnt(eval_cnt));
`else
   branch_cond_unit #(.ADDR_W(8)) dut (
      .clk(clk), .reset(reset), .status(status), .flags_wr(flags_wr), .bus(bus));
`endif

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // reference: jump taken? (-1 = illegal code)
   function automatic int model(input int cond, input logic [3:0] st);
      bit z, n, c, v;
      z = st[3]; n = st[2]; c = st[1]; v = st[0];
      case (cond)
         0: return 1;
         1: return int'(z);
         2: return int'(!z);
         3: return int'(!z && n == v);
         4: return int'(n == v);
         5: return int'(n != v);
         6: return int'(z || n != v);
         7: return int'(c);
         8: return int'(!c);
         9: return int'(v);
         10: return int'(!v);
         default: return -1;
      endcase
   endfunction

   // one request; flags_wr high for nhaz cycles starting at accept, status moves st0->st1
   // when the write completes; result held for 'hold' cycles of backpressure
   task automatic run_branch(input string tag, input int cond, input logic [3:0] st0,
                             input logic [3:0] st1, input logic [7:0] tgt,
                             input logic [7:0] pc, input int nhaz, input int hold);
      int m, edges;
      logic [7:0] exp_pc;
      m = model(cond, st1);
      exp_pc = (m == 1) ? tgt : pc;
      @(negedge clk);
      chk({tag, "/ready"}, 32'(bus.br_ready), 32'd1);
      bus.br_valid = 1'b1; bus.br_cond = 4'(cond); bus.br_target = tgt; bus.pc_plus1 = pc;
      status = st0; flags_wr = (nhaz > 0);
      @(posedge clk); #1;
      bus.br_valid = 1'b0; bus.br_cond = 4'hx; bus.br_target = 8'hxx; bus.pc_plus1 = 8'hxx;
      edges = 1;
      while (!bus.res_valid && edges < 20) begin
         @(negedge clk);
         flags_wr = (edges < nhaz);
         if (edges >= nhaz) status = st1;
         @(posedge clk); #1;
         edges++;
      end
      flags_wr = 1'b0;
      chk({tag, "/latency"}, 32'(edges), 32'(2 + nhaz));
      for (int i = 0; i <= hold; i++) begin
         chk({tag, "/res_valid"}, 32'(bus.res_valid), 32'd1);
         chk({tag, "/no_ready"}, 32'(bus.br_ready), 32'd0);
         chk({tag, "/take"}, 32'(bus.take), 32'(m == 1));
         chk({tag, "/next_pc"}, 32'(bus.next_pc), 32'(exp_pc));
         chk({tag, "/illegal"}, 32'(bus.illegal), 32'(m < 0));
         if (i < hold) begin @(negedge clk); status = 4'($urandom); @(posedge clk); #1; end
      end
      @(negedge clk); bus.res_ready = 1'b1;
      @(posedge clk); #1; bus.res_ready = 1'b0;
      exp_eval++;
      if (m == 1) exp_taken++;
      chk({tag, "/release_ready"}, 32'(bus.br_ready), 32'd1);
      chk({tag, "/release_valid"}, 32'(bus.res_valid), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk); reset = 1'b1;
      repeat (2) @(posedge clk);
      #1; reset = 1'b0;
      exp_eval = 0; exp_taken = 0;
   endtask

   initial begin
      reset = 1'b1; status = '0; flags_wr = 1'b0;
      bus.br_valid = 1'b0; bus.br_cond = '0; bus.br_target = '0; bus.pc_plus1 = '0;
      bus.res_ready = 1'b0;

      // T1 reset
      do_reset();
      chk("t1/br_ready", 32'(bus.br_ready), 32'd1);
      chk("t1/res_valid", 32'(bus.res_valid), 32'd0);
      chk("t1/take", 32'(bus.take), 32'd0);
      chk("t1/next_pc", 32'(bus.next_pc), 32'd0);
      chk("t1/illegal", 32'(bus.illegal), 32'd0);

      // T2 JEQ taken, T3 JGT with two-cycle hazard
      run_branch("t2", 1, 4'b1000, 4'b1000, 8'h40, 8'h11, 0, 0);
      run_branch("t3", 3, 4'b0000, 4'b1000, 8'h77, 8'h22, 2, 0);

      // T4 full table sweep
      for (int c = 0; c < 16; c++)
         for (int s = 0; s < 16; s++)
            run_branch("t4", c, 4'(s), 4'(s), 8'($urandom), 8'($urandom), 0, 0);

      // T5 backpressure
      run_branch("t5", 0, 4'b0000, 4'b0000, 8'h99, 8'h05, 0, 5);

      // randomized traffic with hazards and backpressure
      for (int k = 0; k < 60; k++) begin
         int nh;
         logic [3:0] s0, s1;
         nh = int'($urandom_range(0, 3));
         s0 = 4'($urandom);
         s1 = (nh > 0) ? 4'($urandom) : s0;
         run_branch("rand", int'($urandom_range(0, 15)), s0, s1, 8'($urandom), 8'($urandom),
                    nh, int'($urandom_range(0, 3)));
      end
`ifdef BRANCH_STATS_EN
      chk("stats/eval", 32'(eval_cnt), 32'(exp_eval & 16'hFFFF));
      chk("stats/taken", 32'(taken_cnt), 32'(exp_taken & 16'hFFFF));
`endif

      // T6 reset while holding for a flag write drops the request
      @(negedge clk);
      bus.br_valid = 1'b1; bus.br_cond = 4'd0; bus.br_target = 8'h33; bus.pc_plus1 = 8'h44;
      flags_wr = 1'b1;
      @(posedge clk); #1; bus.br_valid = 1'b0;
      chk("t6/hold_not_ready", 32'(bus.br_ready), 32'd0);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0; flags_wr = 1'b0;
      exp_eval = 0; exp_taken = 0;
      chk("t6/ready", 32'(bus.br_ready), 32'd1);
      chk("t6/res_valid", 32'(bus.res_valid), 32'd0);
      chk("t6/next_pc", 32'(bus.next_pc), 32'd0);
      repeat (3) begin
         @(posedge clk); #1;
         chk("t6/quiet", 32'(bus.res_valid), 32'd0);
      end
      // 3 taken out of 5
      run_branch("t6a", 0, 4'b0000, 4'b0000, 8'h10, 8'h01, 0, 0);
      run_branch("t6b", 1, 4'b0000, 4'b0000, 8'h20, 8'h02, 0, 0);
      run_branch("t6c", 7, 4'b0010, 4'b0010, 8'h30, 8'h03, 1, 0);
      run_branch("t6d", 12, 4'b1111, 4'b1111, 8'h40, 8'h04, 0, 0);
      run_branch("t6e", 5, 4'b0100, 4'b0100, 8'h50, 8'h05, 0, 1);
`ifdef BRANCH_STATS_EN
      chk("t6/taken_cnt", 32'(taken_cnt), 32'd3);
      chk("t6/eval_cnt", 32'(eval_cnt), 32'd5);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
